mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the pipeline CPU.
- Sits beside the combinational ALU in the EX stage and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Unlike the single-cycle ALU, it runs multi-cycle operations over WIDTH+1 cycles, reports busy so the hazard unit can stall MFHI/MFLO and further MDU ops, and supports cancellation on pipeline flush.

Parameters:
- WIDTH, 32, operand, HI and LO width in bits; must be >= 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  issue strobe; op/a/b are valid when high.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=no-op.
- a  in  WIDTH  rs operand (dividend / multiplicand / MT source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- cancel  in  1  flush: abort the in-flight operation.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when HI/LO receive a new MULT/DIV result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - busy=0, done=0, hi=0, lo=0; internal state IDLE; counter=0.
  - Takes effect immediately, including mid-operation; the partial result is discarded.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1, cancel=0, op in 0..3 at edge E0: latch |a|, |b| (signed ops) or a, b (unsigned ops); latch the result sign(s) and the operation type.
  - At E0 also: counter=0, busy=1 from E0, state goes to RUN.
  - start=1 with op 4/5 (cancel=0): hi (op 4) or lo (op 5) is written with a at that edge; busy stays 0; done stays 0.
  - op 6/7, or start together with cancel: ignored.
- RUN: one radix-2 step per cycle (shift-add multiply, restoring divide); counter increments; after WIDTH steps, go to FIX.
- FIX (1 cycle), at edge E(WIDTH+1):
  - Signed correction: negate the product if the operand signs differ; quotient negative if the signs differ; remainder takes the sign of the dividend.
  - hi/lo written; busy=0; done=1 for exactly one cycle; state goes to IDLE.
- Latency and ordering:
  - busy is high for WIDTH+1 cycles; for WIDTH=32, the result is visible 33 cycles after the issue edge.
  - A new start is accepted in the same cycle done is high.
- Results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder.
- Divide by zero: lo = all ones; hi = a (the raw dividend, for both signed and unsigned). Still takes the full WIDTH+1 cycles.
- Signed overflow (DIV of most-negative value by -1): lo = most-negative value, hi = 0. No trap.
- Operations while busy:
  - start while busy=1 is ignored, including MTHI/MTLO; the hazard unit must stall.
  - hi/lo hold their previous values until the FIX edge.
- Cancel:
  - cancel=1 while busy (RUN or FIX): next edge busy=0, done=0, state IDLE, hi/lo unchanged.
  - cancel has priority over the FIX write.
  - cancel while IDLE has no effect except suppressing a simultaneous start.
- Sizes:
  - Counter width is clog2(WIDTH+1).
  - The divide datapath uses a WIDTH+1-bit remainder to hold the borrow; the signed magnitude of the most-negative value is handled as unsigned WIDTH bits.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD b=5 -> busy high for exactly 33 cycles; done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7 after 33 cycles.
- MTHI a=0x12345678 while idle -> hi updates next edge, busy never rises; same MTHI issued while a DIV is busy -> ignored, final hi = DIV remainder.
- Start DIVU 100/7 (hi/lo preset 0xAAAA/0x5555), assert cancel at cycle 10 -> busy low next edge, no done, hi/lo remain 0xAAAA/0x5555; start MULT 3*4 in the done cycle of a prior op -> accepted, lo=12.
- Drop rst_n asynchronously mid-RUN -> busy, done, hi, lo all 0 immediately, without waiting for a clock edge; after release, DIVU 9/3 yields lo=3, hi=0.

Source files
------------

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit owning the HI/LO register pair.
// Executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles (WIDTH radix-2 steps plus
// one sign-fix cycle) and MTHI/MTLO in a single edge.
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   start, op      - issue strobe and opcode (0 MULT, 1 MULTU, 2 DIV, 3 DIVU,
//                    4 MTHI, 5 MTLO, 6/7 no-op)
//   a, b           - rs / rt operands
//   cancel         - pipeline flush, aborts the in-flight operation
//   busy, done     - operation in progress / one-cycle result-written pulse
//   hi, lo         - HI and LO registers
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 is_div;
  logic                 neg_q;   // negate product / quotient
  logic                 neg_r;   // negate remainder (dividend was negative)
  logic                 div0;
  logic [WIDTH-1:0]     dvs;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     a_raw;   // raw dividend, returned on divide by zero
  logic [2*WIDTH-1:0]   acc;     // product, or quotient/dividend in low half
  logic [WIDTH-1:0]     rem;

  logic                 sgn_op_c;
  logic [WIDTH-1:0]     a_mag_c;
  logic [WIDTH-1:0]     b_mag_c;
  logic [WIDTH:0]       mul_sum_c;
  logic [WIDTH:0]       div_sh_c;
  logic [WIDTH:0]       div_diff_c;

  // Operand magnitudes and one radix-2 step of each datapath.
  // The most-negative value negates to itself, which is its correct
  // unsigned magnitude.
  always_comb begin
    sgn_op_c   = ~op[0];
    a_mag_c    = (sgn_op_c && a[WIDTH-1]) ? -a : a;
    b_mag_c    = (sgn_op_c && b[WIDTH-1]) ? -b : b;
    mul_sum_c  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, dvs};
    div_sh_c   = {rem, acc[WIDTH-1]};
    div_diff_c = div_sh_c - {1'b0, dvs};
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      dvs    <= '0;
      a_raw  <= '0;
      acc    <= '0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            if (!op[2]) begin
              state  <= RUN;
              busy   <= 1'b1;
              cnt    <= '0;
              is_div <= op[1];
              a_raw  <= a;
              div0   <= op[1] && (b == '0);
              neg_q  <= sgn_op_c && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r  <= sgn_op_c && a[WIDTH-1];
              dvs    <= op[1] ? b_mag_c : a_mag_c;
              acc    <= {{WIDTH{1'b0}}, (op[1] ? a_mag_c : b_mag_c)};
              rem    <= '0;
            end else if (!op[1]) begin
              if (op[0]) lo <= a;
              else       hi <= a;
            end
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (is_div) begin
              // Restoring step: keep the trial difference unless it borrowed.
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~div_diff_c[WIDTH]};
              rem <= div_diff_c[WIDTH] ? div_sh_c[WIDTH-1:0] : div_diff_c[WIDTH-1:0];
            end else begin
              acc <= acc[0] ? {mul_sum_c, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= neg_q ? -acc : acc;
            end else if (div0) begin
              lo <= '1;
              hi <= a_raw;
            end else begin
              lo <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
              hi <= neg_r ? -rem : rem;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed bench for mdu_iter (WIDTH=32) with a result scoreboard.
module tb_mdu_iter;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb[$];

  int errors    = 0;
  int checks    = 0;
  int cyc       = 0;
  int issue_cyc = 0;
  int busy_run  = 0;
  int done_cnt  = 0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count busy-high and done-high samples between edges.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_run = busy_run + 1;
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the issue edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (o < 3'd4) busy_run = 0;
    @(negedge clk);
    start = 1'b0;
    if (o < 3'd4) issue_cyc = cyc;
  endtask

  task automatic push(input logic [W-1:0] h, input logic [W-1:0] l);
    exp_t e;
    e.hi = h;
    e.lo = l;
    sb.push_back(e);
  endtask

  // Waits (bounded) for done, then checks timing and the scoreboard head.
  task automatic wait_result(input string tag);
    int   n = 0;
    exp_t e;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_latency"}, 64'(cyc - issue_cyc), 64'd33);
    chk({tag, "_busy_len"}, 64'(busy_run), 64'd33);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
      chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] h, input logic [W-1:0] l);
    push(h, l);
    issue(o, x, y);
    wait_result(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int done_base;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 3'd0;
    a      = '0;
    b      = '0;
    cancel = 1'b0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_zero_s", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("mult_pos", 3'd0, 32'd1234, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_F65C);

    // MTHI while idle: immediate write, no busy, no done.
    issue(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    @(negedge clk);
    chk("mthi_busy_later", 64'(busy), 64'd0);

    // MTHI while a DIV runs is dropped.
    push(32'd2, 32'd14);
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_busy_ignored", 64'(hi), 64'h1234_5678);
    wait_result("div_after_mthi");
    @(negedge clk);

    // Cancel mid-run leaves HI/LO untouched and raises no done.
    issue(3'd4, 32'h0000_AAAA, 32'd0);
    issue(3'd5, 32'h0000_5555, 32'd0);
    chk("preset_hi", 64'(hi), 64'h0000_AAAA);
    chk("preset_lo", 64'(lo), 64'h0000_5555);
    done_base = done_cnt;
    issue(3'd3, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    chk("cancel_no_done", 64'(done_cnt - done_base), 64'd0);
    chk("cancel_hi", 64'(hi), 64'h0000_AAAA);
    chk("cancel_lo", 64'(lo), 64'h0000_5555);

    // New op accepted in the done cycle of the previous one.
    push(32'd2, 32'd14);
    issue(3'd3, 32'd100, 32'd7);
    wait_result("divu_b2b");
    push(32'd0, 32'd12);
    issue(3'd0, 32'd3, 32'd4);
    chk("b2b_accept", 64'(busy), 64'd1);
    wait_result("mult_b2b");
    @(negedge clk);
    chk("b2b_done_pulse", 64'(done), 64'd0);

    // Asynchronous reset mid-RUN clears everything before the next edge.
    issue(3'd3, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("divu_after_rst", 3'd3, 32'd9, 32'd3, 32'd0, 32'd3);

    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
